// File: rtl/fft64_pkg.sv
// Shared definitions for the 64-point FFT result collector.
// Contents: default frame geometry, the collector state encoding, and a
// bit-reversal helper that reorders bit-reversed core output indices.
package fft64_pkg;

    localparam int AW_DEF = 6;
    localparam int N_DEF  = 1 << AW_DEF;
    localparam int DW_DEF = 19;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_t;

    // Reverses the low w bits of a. Bits at and above w come back as zero.
    function automatic logic [15:0] bitrev(input logic [15:0] a, input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w) r[4'(i)] = a[4'(w - 1 - i)];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft64_frame_ram.sv
// Frame buffer: N x 2*DW register file with one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
// Ports:
//   clk    in  write clock
//   we     in  write enable
//   waddr  in  write index
//   wdata  in  {real, imag}
//   raddr  in  read index
//   rdata  out {real, imag} at raddr, combinational
module fft64_frame_ram #(
    parameter int DW = 19,
    parameter int AW = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [2*DW-1:0]   wdata,
    input  logic [AW-1:0]     raddr,
    output logic [2*DW-1:0]   rdata
);

    localparam int N = 1 << AW;

    logic [2*DW-1:0] mem [N];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft64_result_collector.sv
// Collects one 64-sample FFT core output frame into a buffer indexed by ADDR,
// then replays it in index order on a valid/ready stream with the frame's
// sticky overflow flags. Frames arriving while a frame is still being drained,
// or restarting mid-capture, are discarded and counted in DROP_CNT.
// Ports:
//   CLK, RST            clock, async active-high reset
//   ED, RDY, ADDR       core sample enable, frame-start strobe, sample index
//   DOR, DOI            core sample real/imag
//   OVF1, OVF2          core overflow flags
//   M_VALID, M_READY    output stream handshake
//   M_DR, M_DI, M_IDX   output sample and its index
//   M_LAST, M_OVF       last-beat marker, {OVF2,OVF1} of the frame
//   BUSY, DROP_CNT      activity flag, saturating dropped-frame count
//
// state   | meaning
// IDLE    | waiting for RDY with ED to start a frame
// CAPTURE | writing samples until N have been stored
// DRAIN   | replaying the buffer; incoming frames are dropped
module fft64_result_collector
    import fft64_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int AW     = AW_DEF,
    parameter bit BITREV = 1'b0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          ED,
    input  logic          RDY,
    input  logic [AW-1:0] ADDR,
    input  logic [DW-1:0] DOR,
    input  logic [DW-1:0] DOI,
    input  logic          OVF1,
    input  logic          OVF2,
    output logic          M_VALID,
    input  logic          M_READY,
    output logic [DW-1:0] M_DR,
    output logic [DW-1:0] M_DI,
    output logic [AW-1:0] M_IDX,
    output logic          M_LAST,
    output logic [1:0]    M_OVF,
    output logic          BUSY,
    output logic [7:0]    DROP_CNT
);

    state_t          state;
    logic [AW-1:0]   wr_cnt;
    logic [AW:0]     rd_ptr;     // extra bit marks "all N beats loaded"
    logic [1:0]      frame_ovf;
    logic [AW-1:0]   wr_addr;
    logic [2*DW-1:0] rd_data;
    logic            we;
    logic            drop;
    logic            load;
    logic            hs;

    assign wr_addr = BITREV ? AW'(bitrev(16'(ADDR), AW)) : ADDR;
    assign we      = ED && ((state == ST_IDLE) ? RDY : (state == ST_CAPTURE));
    assign drop    = ED && RDY && (state != ST_IDLE);
    assign load    = (state == ST_DRAIN) && (!M_VALID || M_READY) && !rd_ptr[AW];
    assign hs      = M_VALID && M_READY;
    assign BUSY    = (state != ST_IDLE);

    fft64_frame_ram #(.DW(DW), .AW(AW)) u_ram (
        .clk   (CLK),
        .we    (we),
        .waddr (wr_addr),
        .wdata ({DOR, DOI}),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            wr_cnt    <= '0;
            rd_ptr    <= '0;
            frame_ovf <= '0;
            M_VALID   <= 1'b0;
            M_DR      <= '0;
            M_DI      <= '0;
            M_IDX     <= '0;
            M_LAST    <= 1'b0;
            M_OVF     <= '0;
            DROP_CNT  <= '0;
        end else begin
            if (drop && (DROP_CNT != 8'hFF)) DROP_CNT <= DROP_CNT + 8'd1;

            case (state)
                ST_IDLE: begin
                    if (ED && RDY) begin
                        wr_cnt    <= AW'(1);
                        frame_ovf <= {OVF2, OVF1};
                        state     <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (ED) begin
                        if (RDY) begin
                            // Premature restart: this sample opens a new frame.
                            wr_cnt    <= AW'(1);
                            frame_ovf <= {OVF2, OVF1};
                        end else begin
                            wr_cnt    <= wr_cnt + 1'b1;
                            frame_ovf <= frame_ovf | {OVF2, OVF1};
                            if (wr_cnt == {AW{1'b1}}) begin
                                state  <= ST_DRAIN;
                                rd_ptr <= '0;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (load) begin
                        M_DR    <= rd_data[2*DW-1:DW];
                        M_DI    <= rd_data[DW-1:0];
                        M_IDX   <= rd_ptr[AW-1:0];
                        M_LAST  <= (rd_ptr[AW-1:0] == {AW{1'b1}});
                        M_OVF   <= frame_ovf;
                        M_VALID <= 1'b1;
                        rd_ptr  <= rd_ptr + 1'b1;
                    end else if (hs) begin
                        M_VALID <= 1'b0;
                    end
                    if (hs && M_LAST) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft64_result_collector.sv
module tb_fft64_result_collector;

    localparam int DW = 19;
    localparam int AW = 6;
    localparam int N  = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          ED = 1'b0, RDY = 1'b0;
    logic [AW-1:0] ADDR = '0;
    logic [DW-1:0] DOR = '0, DOI = '0;
    logic          OVF1 = 1'b0, OVF2 = 1'b0;
    logic          M_READY = 1'b0;

    logic          a_valid, a_last, a_busy, b_valid, b_last, b_busy;
    logic [DW-1:0] a_dr, a_di, b_dr, b_di;
    logic [AW-1:0] a_idx, b_idx;
    logic [1:0]    a_ovf, b_ovf;
    logic [7:0]    a_drop, b_drop;

    always #5 CLK = ~CLK;

    fft64_result_collector #(.DW(DW), .AW(AW), .BITREV(1'b0)) dut (
        .CLK(CLK), .RST(RST), .ED(ED), .RDY(RDY), .ADDR(ADDR), .DOR(DOR), .DOI(DOI),
        .OVF1(OVF1), .OVF2(OVF2), .M_VALID(a_valid), .M_READY(M_READY), .M_DR(a_dr),
        .M_DI(a_di), .M_IDX(a_idx), .M_LAST(a_last), .M_OVF(a_ovf), .BUSY(a_busy),
        .DROP_CNT(a_drop)
    );

    fft64_result_collector #(.DW(DW), .AW(AW), .BITREV(1'b1)) dut_br (
        .CLK(CLK), .RST(RST), .ED(ED), .RDY(RDY), .ADDR(ADDR), .DOR(DOR), .DOI(DOI),
        .OVF1(OVF1), .OVF2(OVF2), .M_VALID(b_valid), .M_READY(M_READY), .M_DR(b_dr),
        .M_DI(b_di), .M_IDX(b_idx), .M_LAST(b_last), .M_OVF(b_ovf), .BUSY(b_busy),
        .DROP_CNT(b_drop)
    );

    typedef struct packed {
        logic [AW-1:0] idx;
        logic          last;
        logic [1:0]    ovf;
        logic [DW-1:0] dr;
        logic [DW-1:0] di;
    } beat_t;

    beat_t got_a[$], got_b[$], exp_a[$], exp_b[$];
    int    errors = 0;
    int    checks = 0;
    int    hold_err = 0;

    // Frame under transmission, stored by core ADDR; ord gives send order.
    logic [DW-1:0] s_dr [N];
    logic [DW-1:0] s_di [N];
    logic          s_o1 [N];
    logic          s_o2 [N];
    int            ord  [N];

    // Stream monitor: records accepted beats and flags any change while stalled.
    beat_t cur_a, cur_b, prev_a;
    logic  stall_a = 1'b0;
    always @(negedge CLK) begin
        cur_a = {a_idx, a_last, a_ovf, a_dr, a_di};
        cur_b = {b_idx, b_last, b_ovf, b_dr, b_di};
        if (RST) begin
            stall_a = 1'b0;
        end else begin
            if (a_valid && M_READY) got_a.push_back(cur_a);
            if (b_valid && M_READY) got_b.push_back(cur_b);
            if (stall_a && (!a_valid || cur_a !== prev_a)) hold_err++;
            stall_a = a_valid && !M_READY;
            prev_a  = cur_a;
        end
    end

    function automatic int brev(input int x);
        int r = 0;
        for (int i = 0; i < AW; i++)
            if ((x >> i) & 1) r = r | (1 << (AW - 1 - i));
        return r;
    endfunction

    function automatic void gen_frame(input int mode, input int o1_at, input int o2_at,
                                      input int order);
        for (int a = 0; a < N; a++) begin
            s_dr[a] = (mode == 0) ? DW'(a)  : DW'($urandom);
            s_di[a] = (mode == 0) ? DW'(-a) : DW'($urandom);
            s_o1[a] = (a == o1_at);
            s_o2[a] = (a == o2_at);
            ord[a]  = order ? brev(a) : a;
        end
    endfunction

    // Reference: beat i carries the sample whose ADDR is i (or bitrev(i) for the
    // bit-reversing instance), flagged with the OR of every overflow in the frame.
    function automatic void build_expected();
        logic [1:0] ovf = 2'b00;
        beat_t      bt;
        exp_a.delete();
        exp_b.delete();
        for (int a = 0; a < N; a++) ovf = ovf | {s_o2[a], s_o1[a]};
        for (int i = 0; i < N; i++) begin
            bt.idx = AW'(i); bt.last = (i == N - 1); bt.ovf = ovf;
            bt.dr = s_dr[i]; bt.di = s_di[i];
            exp_a.push_back(bt);
            bt.dr = s_dr[brev(i)]; bt.di = s_di[brev(i)];
            exp_b.push_back(bt);
        end
    endfunction

    function automatic int frame_bad();
        int bad = 0;
        if (got_a.size() != N) bad += 1000;
        if (got_b.size() != N) bad += 1000;
        for (int i = 0; i < N; i++) begin
            if (i < got_a.size() && got_a[i] !== exp_a[i]) bad++;
            if (i < got_b.size() && got_b[i] !== exp_b[i]) bad++;
        end
        return bad;
    endfunction

    function automatic void clear_got();
        got_a.delete();
        got_b.delete();
        hold_err = 0;
    endfunction

    task automatic put_idle(input logic ed, input logic rdy);
        @(posedge CLK); #1;
        ED = ed; RDY = rdy; ADDR = AW'($urandom);
        DOR = DW'($urandom); DOI = DW'($urandom);
        OVF1 = 1'b0; OVF2 = 1'b0;
    endtask

    task automatic drive_frame(input bit gap, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            if (gap) put_idle(1'b0, 1'($urandom_range(0, 1)));
            @(posedge CLK); #1;
            ED = 1'b1; RDY = (k == 0); ADDR = AW'(ord[k]);
            DOR = s_dr[ord[k]]; DOI = s_di[ord[k]];
            OVF1 = s_o1[ord[k]]; OVF2 = s_o2[ord[k]];
        end
        @(posedge CLK); #1;
        ED = 1'b0; RDY = 1'b0; OVF1 = 1'b0; OVF2 = 1'b0;
    endtask

    // mode 0: ready held high, 1: ready 1,0,1,0..., 2: random ready.
    task automatic wait_drain(input int mode);
        for (int n = 0; n < 1000; n++) begin
            @(posedge CLK); #1;
            M_READY = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(n % 2 == 0) : 1'($urandom_range(0, 1));
            if (got_a.size() >= N && got_b.size() >= N && !a_busy && !b_busy) break;
        end
        M_READY = 1'b1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({a_valid, a_busy, a_last, a_ovf, a_idx, a_drop, a_dr, a_di} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: valid=%0b busy=%0b idx=%0d drop=%0d dr=%h want all 0",
                     a_valid, a_busy, a_idx, a_drop, a_dr);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (4) put_idle(1'b0, 1'b1);
        repeat (4) put_idle(1'b1, 1'b0);
        @(posedge CLK); #1;
        checks++;
        if ({a_busy, b_busy, a_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_idle_gating: busy=%0b valid=%0b want 0", a_busy, a_valid);
        end
    endtask

    task automatic test_basic();
        int bad;
        clear_got();
        M_READY = 1'b1;
        gen_frame(0, -1, -1, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        @(negedge CLK);
        checks++;
        if (a_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_latency_early: M_VALID=%0b at t want 0", a_valid);
        end
        @(negedge CLK);
        checks++;
        if ({a_valid, a_idx} !== {1'b1, AW'(0)}) begin
            errors++;
            $display("FAIL basic_latency: M_VALID=%0b idx=%0d at t+1 want 1/0", a_valid, a_idx);
        end
        wait_drain(0);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL basic_frame: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
        checks++;
        if ({a_busy, a_valid, a_drop} !== 10'd0) begin
            errors++;
            $display("FAIL basic_done: busy=%0b valid=%0b drop=%0d want 0", a_busy, a_valid, a_drop);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        clear_got();
        gen_frame(1, -1, -1, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        wait_drain(1);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_frame: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL bp_hold: changes_while_stalled=%0d want 0", hold_err);
        end
        checks++;
        if (a_drop !== 8'd0) begin
            errors++;
            $display("FAIL bp_drop: DROP_CNT=%0d want 0", a_drop);
        end
    endtask

    task automatic test_ed_gaps();
        int bad;
        clear_got();
        gen_frame(1, 7, -1, 1);
        build_expected();
        drive_frame(1'b1, 0, N - 1);
        repeat (4) put_idle(1'b0, 1'b0);
        checks++;
        if ({a_busy, a_valid} !== 2'b10) begin
            errors++;
            $display("FAIL gaps_63_samples: busy=%0b valid=%0b want 1/0", a_busy, a_valid);
        end
        drive_frame(1'b0, N - 1, N);
        wait_drain(2);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL gaps_frame: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
        checks++;
        if (hold_err !== 0) begin
            errors++;
            $display("FAIL gaps_hold: changes_while_stalled=%0d want 0", hold_err);
        end
    endtask

    task automatic test_drop_in_drain();
        int bad;
        clear_got();
        M_READY = 1'b0;
        gen_frame(1, -1, -1, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        repeat (3) @(posedge CLK);
        #1;
        checks++;
        if ({a_valid, a_idx} !== {1'b1, AW'(0)}) begin
            errors++;
            $display("FAIL drop_stalled: valid=%0b idx=%0d want 1/0", a_valid, a_idx);
        end
        gen_frame(1, 3, 9, 0);
        drive_frame(1'b0, 0, N);
        checks++;
        if ({a_drop, b_drop} !== {8'd1, 8'd1}) begin
            errors++;
            $display("FAIL drop_count: DROP_CNT=%0d/%0d want 1", a_drop, b_drop);
        end
        wait_drain(0);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL drop_frame1_data: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
        clear_got();
        gen_frame(1, -1, -1, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        wait_drain(0);
        bad = frame_bad();
        checks++;
        if (bad !== 0 || a_drop !== 8'd1) begin
            errors++;
            $display("FAIL drop_next_frame: bad=%0d drop=%0d want 0/1", bad, a_drop);
        end
    endtask

    task automatic test_restart();
        int bad;
        clear_got();
        M_READY = 1'b1;
        gen_frame(1, 5, -1, 0);
        drive_frame(1'b0, 0, 30);
        gen_frame(1, -1, -1, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        wait_drain(0);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL restart_frame: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
        checks++;
        if (a_drop !== 8'd2) begin
            errors++;
            $display("FAIL restart_drop: DROP_CNT=%0d want 2", a_drop);
        end
    endtask

    task automatic test_ovf_bitrev();
        int         bad;
        logic [DW-1:0] dr32;
        clear_got();
        gen_frame(1, -1, 10, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        wait_drain(2);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ovf_frame: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
        checks++;
        if (got_a.size() == 0 || got_a[0].ovf !== 2'b10) begin
            errors++;
            $display("FAIL ovf_flag: first M_OVF=%b want 10", (got_a.size() != 0) ? got_a[0].ovf : 2'bxx);
        end
        dr32 = 'x;
        foreach (got_b[i]) if (got_b[i].idx == AW'(32)) dr32 = got_b[i].dr;
        checks++;
        if (dr32 !== s_dr[1]) begin
            errors++;
            $display("FAIL bitrev_idx32: M_DR=%h want %h (ADDR 1 sample)", dr32, s_dr[1]);
        end
        clear_got();
        gen_frame(1, -1, -1, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        wait_drain(0);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL ovf_clean_frame: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
    endtask

    task automatic test_reset_mid_drain();
        int bad;
        bit found = 0;
        clear_got();
        M_READY = 1'b1;
        gen_frame(1, -1, -1, 0);
        drive_frame(1'b0, 0, N);
        for (int n = 0; n < 300; n++) begin
            @(negedge CLK);
            if (a_valid && a_idx == AW'(20)) begin found = 1; break; end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL rst_wait_beat20: beat 20 not seen within 300 cycles");
        end
        RST = 1'b1;
        #1;
        checks++;
        if ({a_valid, a_busy, a_drop, b_valid} !== 11'd0) begin
            errors++;
            $display("FAIL rst_async: valid=%0b busy=%0b drop=%0d want 0", a_valid, a_busy, a_drop);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_got();
        for (int n = 0; n < 100; n++) put_idle(1'($urandom_range(0, 1)), 1'b0);
        @(posedge CLK); #1;
        checks++;
        if (got_a.size() !== 0 || got_b.size() !== 0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_beats: beats=%0d busy=%0b want 0/0", got_a.size(), a_busy);
        end
        gen_frame(1, -1, -1, 0);
        build_expected();
        drive_frame(1'b0, 0, N);
        wait_drain(0);
        bad = frame_bad();
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL rst_next_frame: bad=%0d beats_a=%0d want bad=0", bad, got_a.size());
        end
    endtask

    task automatic test_drop_saturation();
        // First cycle opens a frame; every later ED&RDY cycle is a restart drop.
        repeat (255) put_idle(1'b1, 1'b1);
        @(posedge CLK); #1;
        checks++;
        if (a_drop !== 8'd254) begin
            errors++;
            $display("FAIL sat_254: DROP_CNT=%0d want 254", a_drop);
        end
        repeat (50) put_idle(1'b1, 1'b1);
        @(posedge CLK); #1;
        checks++;
        if (a_drop !== 8'd255 || b_drop !== 8'd255) begin
            errors++;
            $display("FAIL sat_255: DROP_CNT=%0d/%0d want 255", a_drop, b_drop);
        end
        ED = 1'b0; RDY = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_ed_gaps();
        test_drop_in_drain();
        test_restart();
        test_ovf_bitrev();
        test_reset_mid_drain();
        test_drop_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
